cordic_nco_src: RTL
===================

CORDIC_NCO_SRC -- requirements
Module: cordic_nco_src

Interface
REQ-001 SHALL have parameter DW, default 10: width of the amplitude and of xout/yout, Q1.(DW-1).
REQ-002 SHALL have parameter AW, default DW: width of aout, Q1.(AW-1), where [-1,1) maps to [-pi,pi).
REQ-003 SHALL have parameter PW, default 24: width of the phase accumulator, PW >= AW.
REQ-004 SHALL have parameter LW, default 16: width of the frame-length field.
REQ-005 SHALL have ports clk in 1 (clock) and rst in 1; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port start in 1: one-cycle start request.
REQ-007 SHALL have port stop in 1: one-cycle request to stop at the end of the current frame.
REQ-008 SHALL have port freq in PW: unsigned phase increment per sample.
REQ-009 SHALL have port phase_ofs in PW: phase offset added to every sample.
REQ-010 SHALL have port amp in DW: signed amplitude.
REQ-011 SHALL have port frame_len in LW: samples per frame; 0 means unframed.
REQ-012 SHALL have port busy out 1: high when state is not IDLE.
REQ-013 SHALL have ports xout, yout out DW signed and aout out AW signed: a CordicStr ROT-mode operand triplet.
REQ-014 SHALL have ports out_last out 1, out_valid out 1 and out_ready in 1: valid/ready stream.

Function
REQ-015 SHALL implement the states IDLE, RUN and STOPPING.
REQ-016 In IDLE, start SHALL sample freq, phase_ofs, amp and frame_len into shadow registers, clear acc and the sample counter, and move to RUN; stop SHALL be ignored in IDLE.
REQ-017 In RUN, stop SHALL move to STOPPING; start SHALL be ignored in RUN and STOPPING.
REQ-018 A new sample SHALL be loaded into the output register when busy and (~out_valid | (out_valid & out_ready)).
REQ-019 Output contents SHALL be xout=amp_s, yout=0, aout=(acc+phase_ofs_s)[PW-1 -: AW], truncated, with modulo-2^PW wrap.
REQ-020 acc SHALL advance by freq_s only on a sample load; the phase of sample k SHALL be k*freq_s+phase_ofs_s mod 2^PW.
REQ-021 out_last SHALL be 1 on the sample whose counter equals frame_len_s-1; that load SHALL also clear the counter.
REQ-022 At each frame boundary (out_last load), the shadow freq_s and amp_s SHALL be refreshed from the ports; phase_ofs_s and frame_len_s SHALL stay fixed until the next start.
REQ-023 An out_last load while in STOPPING SHALL move the block to IDLE; the issued sample SHALL remain valid until it is handshaken.
REQ-024 With frame_len_s=0, out_last SHALL stay 0, the shadows SHALL never refresh, and STOPPING SHALL end at the next sample load.
REQ-025 While out_valid=1 and out_ready=0, all outputs SHALL be held stable.
REQ-026 out_valid SHALL clear after a handshake that is not accompanied by a new load.
REQ-027 Latency: start at edge n SHALL give busy=1 after edge n, and the first sample valid after edge n+1.
REQ-028 stop and an out_last load in the same cycle during RUN SHALL move the block directly to IDLE.

Reset
REQ-029 rst SHALL asynchronously force IDLE, acc=0, counter=0 and all shadow registers to 0.
REQ-030 During reset, xout, yout, aout, out_last, out_valid and busy SHALL all be 0.
REQ-031 Reset mid-frame SHALL drop any pending sample without completing the frame.
REQ-032 After reset release, the block SHALL stay in IDLE until start.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, RUN, STOPPING) and the angle-mapping constant (PI_Q = 2^(AW-1)).
REQ-034 There SHALL be one sub-module, nco_phase_acc, containing the accumulator, the offset adder and the truncation.
REQ-035 The output register and valid/ready logic SHALL follow the same stage handshake used by the CORDIC stages, so the block can drive CordicStr directly.

Verification
REQ-036 DW=AW=10, PW=16, freq=0x0400, phase_ofs=0, amp=0x133, frame_len=4, out_ready=1, start -> aout 0,16,32,48 with out_last on the 4th sample, xout=0x133, yout=0.
REQ-037 freq=0x4000, phase_ofs=0x8000 -> aout -512,-256,0,256,-512, showing wrap-around.
REQ-038 out_ready toggled 1,0,0,1 -> no sample lost or duplicated, outputs stable while stalled, phase sequence unchanged.
REQ-039 stop on the 2nd sample of a 4-sample frame -> samples 3 and 4 issued, out_last on the 4th, busy falls after that load, no 5th sample.
REQ-040 freq changed mid-frame from 0x0400 to 0x0800 -> new step 32 appears only from the first sample of the next frame.
REQ-041 rst asserted with out_valid=1 and out_ready=0 -> all outputs 0 immediately; a start after release restarts at aout=phase_ofs.

Source files
------------

// File: rtl/cordic_nco_src_pkg.sv
// Shared definitions for the CORDIC NCO source block.
//   nco_state_e : control FSM states (IDLE, RUN, STOPPING)
//   PI_Q        : angle-mapping constant for the default angle width; the
//                 value 2^(AW-1) corresponds to +pi in Q1.(AW-1) angle units
//   pi_q()      : the same constant computed for an arbitrary angle width
package cordic_nco_src_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } nco_state_e;

  localparam int unsigned AW_DEFAULT = 10;
  localparam int unsigned PI_Q       = 2 ** (AW_DEFAULT - 1);

  // Angle code for +pi at width aw; [-1,1) in Q1.(aw-1) spans [-pi,pi).
  function automatic int unsigned pi_q(input int unsigned aw);
    return 32'(1) << (aw - 1);
  endfunction

endpackage

// File: rtl/cordic_nco_src_phase_acc.sv
// nco_phase_acc: phase accumulator with offset adder and angle truncation.
// The accumulator holds the phase of the next sample to be issued (k*freq,
// modulo 2^PW). The offset is added combinationally and the sum is truncated
// to its top AW bits to form the CORDIC angle operand.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : clear the accumulator (frame-sequence start)
//   adv        : advance the accumulator by freq (sample load)
//   freq       : unsigned phase increment per sample
//   phase_ofs  : phase offset added to every sample
//   angle_c    : truncated angle of the current sample (combinational)
module nco_phase_acc
  import cordic_nco_src_pkg::*;
#(
  parameter int unsigned PW = 24,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [PW-1:0] freq,
  input  logic [PW-1:0] phase_ofs,
  output logic [AW-1:0] angle_c
);

  logic [PW-1:0] acc_q;
  logic [PW-1:0] phase_c;

  // Accumulator; wraps naturally modulo 2^PW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (adv) begin
      acc_q <= acc_q + freq;
    end
  end

  // Offset adder and truncation to the angle width (no rounding).
  assign phase_c = acc_q + phase_ofs;
  assign angle_c = phase_c[PW-1 -: AW];

  // Fractional phase bits below the angle LSB are intentionally discarded.
  generate
    if (PW > AW) begin : g_trunc
      logic unused_low;
      assign unused_low = ^phase_c[PW-AW-1:0];
    end
  endgenerate

endmodule

// File: rtl/cordic_nco_src.sv
// cordic_nco_src: framed NCO operand source for a ROT-mode CORDIC.
// Each issued sample is the triplet (x=amp, y=0, angle=k*freq+phase_ofs),
// presented on a valid/ready stream whose output register behaves like a
// CORDIC pipeline stage, so it can feed the CORDIC input directly.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle start request (honoured only in IDLE)
//   stop            : one-cycle request to stop at the end of the frame
//   freq            : unsigned phase increment per sample (PW bits)
//   phase_ofs       : phase offset added to every sample (PW bits)
//   amp             : signed amplitude, Q1.(DW-1)
//   frame_len       : samples per frame, 0 = unframed
//   busy            : high while the FSM is not IDLE
//   xout, yout      : CORDIC x/y operands, Q1.(DW-1)
//   aout            : CORDIC angle operand, Q1.(AW-1), [-1,1) = [-pi,pi)
//   out_last        : marks the final sample of a frame
//   out_valid/ready : stream handshake
module cordic_nco_src
  import cordic_nco_src_pkg::*;
#(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = DW,
  parameter int unsigned PW = 24,
  parameter int unsigned LW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [PW-1:0]        freq,
  input  logic [PW-1:0]        phase_ofs,
  input  logic signed [DW-1:0] amp,
  input  logic [LW-1:0]        frame_len,
  output logic                 busy,
  output logic signed [DW-1:0] xout,
  output logic signed [DW-1:0] yout,
  output logic signed [AW-1:0] aout,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  nco_state_e state_q;
  nco_state_e state_d;

  // Shadow copies of the configuration captured at start.
  logic [PW-1:0]        freq_s;
  logic [PW-1:0]        phase_ofs_s;
  logic signed [DW-1:0] amp_s;
  logic [LW-1:0]        frame_len_s;
  logic [LW-1:0]        cnt_q;

  logic          start_c;
  logic          load_c;
  logic          framed_c;
  logic          last_c;
  logic [AW-1:0] angle_c;

  // A start is only accepted from IDLE.
  assign start_c = (state_q == IDLE) && start;

  // Stage handshake: refill the output register when it is empty or is
  // being drained this cycle.
  assign load_c = (state_q != IDLE) && (!out_valid || out_ready);

  assign framed_c = (frame_len_s != '0);
  assign last_c   = framed_c && (cnt_q == frame_len_s - LW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A stop coinciding with the frame's last load ends immediately.
        if (stop && load_c && last_c) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        // Unframed streams stop at the very next sample.
        if (load_c && (last_c || !framed_c)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy tracks the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
    end
  end

  // Shadow registers and in-frame sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_s      <= '0;
      phase_ofs_s <= '0;
      amp_s       <= '0;
      frame_len_s <= '0;
      cnt_q       <= '0;
    end else if (start_c) begin
      freq_s      <= freq;
      phase_ofs_s <= phase_ofs;
      amp_s       <= amp;
      frame_len_s <= frame_len;
      cnt_q       <= '0;
    end else if (load_c) begin
      if (last_c) begin
        // Frame boundary: step and amplitude follow the ports from here on.
        cnt_q  <= '0;
        freq_s <= freq;
        amp_s  <= amp;
      end else if (framed_c) begin
        cnt_q <= cnt_q + LW'(1);
      end
    end
  end

  nco_phase_acc #(
    .PW (PW),
    .AW (AW)
  ) u_phase_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_c),
    .adv       (load_c),
    .freq      (freq_s),
    .phase_ofs (phase_ofs_s),
    .angle_c   (angle_c)
  );

  // Output stage register; contents hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xout      <= '0;
      yout      <= '0;
      aout      <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      xout      <= amp_s;
      yout      <= '0;
      aout      <= angle_c;
      out_last  <= last_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
